usart_rx: RTL and testbench
===========================

// Module: usart_rx
// PURPOSE
//  Serial receiver for 8N1 async input. Oversamples rx_pin on the serial clock, reassembles
//  bytes LSB-first and presents them on a valid/ready output register. Sits directly upstream
//  of the echo/transmit path; drives RTS flow control and an activity LED.
// PARAMETERS
//  SYNC_STAGES   2     flops in rx_pin synchronizer (>=2)
//  CPB_WIDTH     12    width of clocks_per_bit input
// PORTS
//  serial_clock    in   1          sole clock (e.g. 3.6864 MHz)
//  reset           in   1          synchronous, active-high
//  clocks_per_bit  in   CPB_WIDTH  serial clocks per bit (32 -> 115200 baud at 3.6864 MHz)
//  rx_pin          in   1          async serial line, idle high
//  rx_data         out  8          received byte, valid while rx_valid=1
//  rx_valid        out  1          byte available
//  rx_ready        in   1          consumer accepts; transfer when rx_valid&&rx_ready
//  framing_error   out  1          1-cycle pulse: stop bit sampled 0
//  overrun         out  1          1-cycle pulse: byte completed while rx_valid still 1
//  rts_pin         out  1          active-low ready-to-receive; =rx_valid (high = hold off)
//  rx_active       out  1          1 while a frame is in progress (LED)
// BEHAVIOUR
//  - Reset: state=IDLE, rx_data=8'h00, rx_valid=0, pulses=0, rts_pin=0, rx_active=0. Reset
//    mid-frame aborts frame silently; held byte is dropped.
//  - rx_pin passes SYNC_STAGES-flop synchronizer; all decisions use synchronized value rxs.
//  - clocks_per_bit latched into cpb_q on leaving IDLE; changes mid-frame ignored. cpb_q<4 is
//    clamped to 4.
//  - States: IDLE -> START -> DATA -> STOP -> IDLE; STOP -> BREAK -> IDLE on error.
//    IDLE: rxs==0 -> START, counter=0, rx_active=1.
//    START: at counter==cpb_q>>1 sample; rxs==1 -> false start, IDLE; else DATA, counter=0.
//    DATA: at counter==cpb_q-1 sample rxs into shift[7] (shift right), bit_cnt++; after 8th
//      bit -> STOP. Counter wraps to 0 on each sample.
//    STOP: at counter==cpb_q-1 sample; 1 -> deliver, IDLE; 0 -> framing_error pulse, byte
//      discarded, BREAK.
//    BREAK: wait rxs==1, then IDLE (no new start detected during line-low break).
//  - Deliver: if rx_valid==0 or (rx_valid&&rx_ready) same cycle -> rx_data<=shift,
//    rx_valid<=1 on next edge (1 cycle after stop sample). Else overrun pulse; old byte kept.
//  - rx_valid&&rx_ready with no deliver -> rx_valid<=0 next edge.
//  - Start edge to rx_valid: SYNC_STAGES + cpb_q/2 + 9*cpb_q + 1 cycles (cpb_q even).
//  - rx_active=0 in IDLE and BREAK, 1 otherwise.
// CONFIGURATION
//  USART_RX_PARITY_EN: defined -> one even-parity bit after bit 7 (state PARITY, sampled like
//    DATA); mismatch drives output parity_error (1-cycle pulse at stop sample) and byte is
//    discarded, return to IDLE if stop=1. Undefined -> no PARITY state, no parity_error port,
//    pure 8N1.
// STRUCTURE
//  - usart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK), CPB_MIN=4 constant.
//  - Sub-module usart_sync: parameterised N-flop synchronizer, reset value 1 (idle line).
// TESTING  (clocks_per_bit=32, SYNC_STAGES=2 unless noted)
//  1. Send 0x55 8N1, rx_ready=1 -> rx_data=0x55, rx_valid 1 cycle, 307 cycles after start edge.
//  2. 10-cycle low glitch on idle line -> no rx_valid, back to IDLE, rx_active pulses then 0.
//  3. Send 0xA3 with stop=0, line held low 100 cycles -> framing_error pulse, no rx_valid,
//     BREAK until line high; next 0x3C received correctly.
//  4. Send 0x11 then 0x22, rx_ready=0 -> rx_data=0x11 kept, overrun pulse at 2nd stop, rts_pin=1.
//  5. Assert reset mid-DATA of 0xFF -> all outputs reset values; next 0x42 received intact.
//  6. USART_RX_PARITY_EN: 0x01 with parity bit 0 -> parity_error pulse, no rx_valid; with 1
//     -> rx_data=0x01.

Source files
------------

// File: rtl/usart_pkg.sv
// usart_pkg: receiver state encoding and baud-divider floor shared by the usart_rx slice
package usart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam int CPB_MIN = 4;

endpackage

// File: rtl/usart_sync.sv
// usart_sync: N-flop synchronizer for an async line, resets to 1 (idle line level)
module usart_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] r;

    // shift the async input through N flops
    always_ff @(posedge clk)
        if (rst) r <= '1;
        else r <= {r[N-2:0], d};

    assign q = r[N-1];

endmodule

// File: rtl/usart_rx.sv
// usart_rx: oversampling 8N1 receiver with valid/ready output; USART_RX_PARITY_EN adds even parity
module usart_rx
    import usart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CPB_WIDTH   = 12
) (
    input  logic                 serial_clock,
    input  logic                 reset,
    input  logic [CPB_WIDTH-1:0] clocks_per_bit,
    input  logic                 rx_pin,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun,
`ifdef USART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 rts_pin,
    output logic                 rx_active
);

    localparam logic [CPB_WIDTH-1:0] CPB_FLOOR = CPB_WIDTH'(CPB_MIN);
    localparam logic [CPB_WIDTH-1:0] ONE       = CPB_WIDTH'(1);
`ifdef USART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = ST_PARITY;
    logic par_q;
`else
    localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

    logic                 rxs;
    logic [2:0]           state;
    logic [CPB_WIDTH-1:0] cnt;
    logic [CPB_WIDTH-1:0] cpb_q;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic                 hit;
    logic                 stop_hit;
    logic                 good;

    usart_sync #(.N(SYNC_STAGES)) u_sync (
        .clk(serial_clock),
        .rst(reset),
        .d  (rx_pin),
        .q  (rxs)
    );

    // sample strobe: mid-bit during START, end of each bit period afterwards
    always_comb begin
        hit      = (state == ST_START) ? (cnt == (cpb_q >> 1)) : (cnt == cpb_q - ONE);
        stop_hit = (state == ST_STOP) && hit;
`ifdef USART_RX_PARITY_EN
        good     = stop_hit && rxs && (par_q == ^shift);
`else
        good     = stop_hit && rxs;
`endif
    end

    // bit-period counter, restarted on every sample and held at 0 while idle or in break
    always_ff @(posedge serial_clock)
        if (reset || state == ST_IDLE || state == ST_BREAK || hit) cnt <= '0;
        else cnt <= cnt + ONE;

    // frame state machine and data shift register
    always_ff @(posedge serial_clock)
        if (reset) begin
            state   <= ST_IDLE;
            cpb_q   <= CPB_FLOOR;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef USART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE:
                    if (!rxs) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                        cpb_q   <= (clocks_per_bit < CPB_FLOOR) ? CPB_FLOOR : clocks_per_bit;
                    end
                ST_START:
                    if (hit) state <= rxs ? ST_IDLE : ST_DATA;
                ST_DATA:
                    if (hit) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= AFTER_DATA;
                    end
`ifdef USART_RX_PARITY_EN
                ST_PARITY:
                    if (hit) begin
                        par_q <= rxs;
                        state <= ST_STOP;
                    end
`endif
                ST_STOP:
                    if (hit) state <= rxs ? ST_IDLE : ST_BREAK;
                ST_BREAK:
                    if (rxs) state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end

    // output register: deliver good bytes, flag errors, drain on handshake
    always_ff @(posedge serial_clock)
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef USART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            framing_error <= stop_hit && !rxs;
            overrun       <= good && rx_valid && !rx_ready;
`ifdef USART_RX_PARITY_EN
            parity_error  <= stop_hit && (par_q != ^shift);
`endif
            if (good && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end

    assign rts_pin   = rx_valid;
    assign rx_active = (state != ST_IDLE) && (state != ST_BREAK);

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed and randomized frames for usart_rx against a frame-level reference model
module tb_usart_rx;

    localparam int S = 2;
`ifdef USART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        serial_clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] clocks_per_bit = 12'd32;
    logic        rx_pin = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        framing_error;
    logic        overrun;
    logic        rts_pin;
    logic        rx_active;
`ifdef USART_RX_PARITY_EN
    logic        parity_error;
`endif

    int checks = 0;
    int errors = 0;
    int fidx, v_at, v_n, fe_n, fe_at, ov_n, act_n, pe_n;
    logic [7:0] v_data;

    always #5 serial_clock = ~serial_clock;

    usart_rx #(.SYNC_STAGES(S), .CPB_WIDTH(12)) dut (
        .serial_clock  (serial_clock),
        .reset         (reset),
        .clocks_per_bit(clocks_per_bit),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
`ifdef USART_RX_PARITY_EN
        .parity_error  (parity_error),
`endif
        .rts_pin       (rts_pin),
        .rx_active     (rx_active)
    );

    // cycles from the first clock edge that sees the start bit to rx_valid
    function automatic int lat(int cpb);
        int c;
        c = (cpb < 4) ? 4 : cpb;
        return S + c / 2 + (9 + PB) * c + 1;
    endfunction

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear();
        fidx = -1; v_at = -1; v_n = 0; fe_n = 0; fe_at = -1; ov_n = 0; act_n = 0; pe_n = 0;
        v_data = 8'h00;
    endtask

    task automatic step();
        @(posedge serial_clock);
        #1;
        fidx++;
        if (rx_valid) begin
            v_n++;
            if (v_at < 0) begin
                v_at = fidx;
                v_data = rx_data;
            end
        end
        if (framing_error) begin
            fe_n++;
            fe_at = fidx;
        end
        if (overrun) ov_n++;
        if (rx_active) act_n++;
`ifdef USART_RX_PARITY_EN
        if (parity_error) pe_n++;
`endif
    endtask

    task automatic idle(int n, logic lvl);
        rx_pin = lvl;
        repeat (n) step();
    endtask

    task automatic send(logic [7:0] d, logic stop, int blen, logic par_bad, int cpb_new);
        logic [10:0] f;
        clear();
`ifdef USART_RX_PARITY_EN
        f = {stop, (^d) ^ par_bad, d, 1'b0};
`else
        f = {par_bad, stop, d, 1'b0};
`endif
        for (int b = 0; b < 10 + PB; b++) begin
            rx_pin = f[b];
            if (b == 1) clocks_per_bit = cpb_new[11:0];
            repeat (blen) step();
        end
    endtask

    initial begin
        int cpb, ce, cnew;
        logic [7:0] d;
        logic stop;

        clear();
        repeat (3) step();
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rts", rts_pin, 0);
        check("reset_active", rx_active, 0);
        check("reset_fe", framing_error, 0);
        check("reset_ov", overrun, 0);
        reset = 1'b0;
        idle(5, 1'b1);

        // 0x55 with consumer ready
        send(8'h55, 1'b1, 32, 1'b0, 32);
        idle(8, 1'b1);
        check("t1_latency", v_at, lat(32));
        check("t1_data", v_data, 8'h55);
        check("t1_valid_len", v_n, 1);
        check("t1_fe", fe_n, 0);
        check("t1_active_len", act_n, lat(32) - 2);

        // short glitch is a false start
        clear();
        idle(10, 1'b0);
        idle(40, 1'b1);
        check("t2_no_valid", v_at, -1);
        check("t2_active_len", act_n, 32 / 2 + 1);
        check("t2_active_end", rx_active, 0);

        // bad stop bit then long break, then a clean frame
        send(8'hA3, 1'b0, 32, 1'b0, 32);
        check("t3_fe_count", fe_n, 1);
        check("t3_fe_time", fe_at, lat(32));
        check("t3_no_valid", v_at, -1);
        clear();
        idle(100, 1'b0);
        check("t3_break_inactive", act_n, 0);
        check("t3_break_fe", fe_n, 0);
        idle(40, 1'b1);
        send(8'h3C, 1'b1, 32, 1'b0, 32);
        idle(8, 1'b1);
        check("t3_next_data", v_data, 8'h3C);
        check("t3_next_latency", v_at, lat(32));

        // consumer stalled: second byte overruns
        rx_ready = 1'b0;
        send(8'h11, 1'b1, 32, 1'b0, 32);
        idle(8, 1'b1);
        check("t4_first_data", v_data, 8'h11);
        check("t4_first_ov", ov_n, 0);
        send(8'h22, 1'b1, 32, 1'b0, 32);
        idle(8, 1'b1);
        check("t4_overrun", ov_n, 1);
        check("t4_data_kept", rx_data, 8'h11);
        check("t4_valid_held", rx_valid, 1);
        check("t4_rts", rts_pin, 1);

        // reset mid-DATA of 0xFF drops held byte and frame
        clear();
        idle(32, 1'b0);
        idle(100, 1'b1);
        reset = 1'b1;
        step();
        check("t5_rx_valid", rx_valid, 0);
        check("t5_rx_data", rx_data, 0);
        check("t5_rts", rts_pin, 0);
        check("t5_active", rx_active, 0);
        reset = 1'b0;
        rx_ready = 1'b1;
        idle(40, 1'b1);
        send(8'h42, 1'b1, 32, 1'b0, 32);
        idle(8, 1'b1);
        check("t5_next_data", v_data, 8'h42);
        check("t5_next_latency", v_at, lat(32));

`ifdef USART_RX_PARITY_EN
        send(8'h01, 1'b1, 32, 1'b1, 32);
        idle(8, 1'b1);
        check("t6_pe_count", pe_n, 1);
        check("t6_pe_no_valid", v_at, -1);
        send(8'h01, 1'b1, 32, 1'b0, 32);
        idle(8, 1'b1);
        check("t6_ok_data", v_data, 8'h01);
        check("t6_ok_pe", pe_n, 0);
`endif

        // randomized frames: divider (incl. clamped values), payload, stop bit, mid-frame divider change
        for (int i = 0; i < 20; i++) begin
            cpb = 2 * $urandom_range(1, 20);
            ce = (cpb < 4) ? 4 : cpb;
            cnew = $urandom_range(4, 60);
            d = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            clocks_per_bit = cpb[11:0];
            send(d, stop, ce, 1'b0, cnew);
            idle(2 * ce, 1'b1);
            if (stop) begin
                check("rnd_data", v_data, d);
                check("rnd_latency", v_at, lat(cpb));
                check("rnd_fe", fe_n, 0);
            end else begin
                check("rnd_err_fe", fe_n, 1);
                check("rnd_err_no_valid", v_at, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
